cam_pattern_gen: RTL and testbench



---
 rtl/cam_pattern_pkg.sv | 44 ++++
 rtl/cam_pattern_gen_if.sv | 22 ++
 rtl/cam_pattern_pixel.sv | 30 +++
 rtl/cam_pattern_gen.sv | 205 ++++++++++++++++++++
 tb/tb_cam_pattern_gen.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/cam_pattern_pkg.sv
// Shared types and colour constants for the camera test-pattern generator.
package cam_pattern_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_VSYNC  = 3'd1,
    ST_VBACK  = 3'd2,
    ST_HBLANK = 3'd3,
    ST_ACTIVE = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    MODE_BARS  = 2'd0,
    MODE_GRAD  = 2'd1,
    MODE_CHECK = 2'd2,
    MODE_FRAME = 2'd3
  } mode_t;

  // RGB565 colour-bar palette, left to right.
  localparam logic [15:0] BAR_WHITE   = 16'hFFFF;
  localparam logic [15:0] BAR_YELLOW  = 16'hFFE0;
  localparam logic [15:0] BAR_CYAN    = 16'h07FF;
  localparam logic [15:0] BAR_GREEN   = 16'h07E0;
  localparam logic [15:0] BAR_MAGENTA = 16'hF81F;
  localparam logic [15:0] BAR_RED     = 16'hF800;
  localparam logic [15:0] BAR_BLUE    = 16'h001F;
  localparam logic [15:0] BAR_BLACK   = 16'h0000;

  function automatic logic [15:0] bar_color(input logic [2:0] idx);
    logic [15:0] c;
    case (idx)
      3'd0:    c = BAR_WHITE;
      3'd1:    c = BAR_YELLOW;
      3'd2:    c = BAR_CYAN;
      3'd3:    c = BAR_GREEN;
      3'd4:    c = BAR_MAGENTA;
      3'd5:    c = BAR_RED;
      3'd6:    c = BAR_BLUE;
      default: c = BAR_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/cam_pattern_gen_if.sv
// Control inputs and DVP-style camera outputs of the pattern generator.
interface cam_pattern_gen_if;
  logic        enable;
  logic [1:0]  mode;
  logic        cmos_vsyn;
  logic        cmos_href;
  logic [7:0]  cmos_data;
  logic        frame_done;
  logic [15:0] frame_cnt;

  // Generator side: takes the run request, drives the camera stream.
  modport master (
    input  enable, mode,
    output cmos_vsyn, cmos_href, cmos_data, frame_done, frame_cnt
  );

  // Consumer side: issues the run request, receives the camera stream.
  modport slave (
    output enable, mode,
    input  cmos_vsyn, cmos_href, cmos_data, frame_done, frame_cnt
  );
endinterface

// File: rtl/cam_pattern_pixel.sv
// Pure combinational RGB565 colour for one pixel position and pattern mode.
module cam_pattern_pixel
  import cam_pattern_pkg::*;
#(
  parameter int SQ_LOG2 = 5
) (
  input  mode_t       i_mode,
  input  logic [15:0] i_x,
  input  logic [15:0] i_y,
  input  logic [2:0]  i_bar,
  input  logic [7:0]  i_frame,
  output logic [15:0] o_pixel
);

  // Only some coordinate bits matter for any given mode.
  logic w_unused;
  assign w_unused = &{1'b0, i_x, i_y};

  // Select the colour for the current pattern.
  always_comb begin
    o_pixel = 16'h0000;
    case (i_mode)
      MODE_BARS:  o_pixel = bar_color(i_bar);
      MODE_GRAD:  o_pixel = {i_x[7:3], i_x[7:2], i_x[7:3]};
      MODE_CHECK: o_pixel = (i_x[SQ_LOG2] ^ i_y[SQ_LOG2]) ? 16'hFFFF : 16'h0000;
      MODE_FRAME: o_pixel = {i_frame, i_frame};
    endcase
  end

endmodule

// File: rtl/cam_pattern_gen.sv
// Camera test-pattern generator: emits VSYNC/HREF framing and an RGB565
// byte stream (high byte first) in one of four synthetic patterns.
module cam_pattern_gen
  import cam_pattern_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int H_BLANK  = 100,
  parameter int V_FRONT  = 1000,
  parameter int V_BACK   = 1000,
  parameter int BAR_W    = 80,
  parameter int SQ_LOG2  = 5
) (
  input  logic              cmos_pclk,
  input  logic              rst,
  cam_pattern_gen_if.master bus
);

  if (H_ACTIVE == 0 || V_ACTIVE == 0 || H_BLANK == 0 ||
      V_FRONT == 0 || V_BACK == 0 || BAR_W == 0) begin : g_bad_zero
    $error("cam_pattern_gen: timing and bar-width parameters must be non-zero");
  end
  if (SQ_LOG2 < 0 || SQ_LOG2 > 15) begin : g_bad_sq
    $error("cam_pattern_gen: SQ_LOG2 must lie in 0..15");
  end

  // Terminal counts for each phase, held at counter width.
  localparam logic [31:0] LAST_VF   = 32'(V_FRONT - 1);
  localparam logic [31:0] LAST_VB   = 32'(V_BACK - 1);
  localparam logic [31:0] LAST_HB   = 32'(H_BLANK - 1);
  localparam logic [31:0] LAST_BYTE = 32'(2 * H_ACTIVE - 1);
  localparam logic [31:0] LAST_BPIX = 32'(BAR_W - 1);
  localparam logic [15:0] LAST_LINE = 16'(V_ACTIVE - 1);

  state_t      r_state,     w_state_nxt;
  logic [31:0] r_cnt,       w_cnt_nxt;
  logic [15:0] r_line,      w_line_nxt;
  logic [15:0] r_x,         w_x_nxt;
  logic        r_phase,     w_phase_nxt;
  logic [2:0]  r_bar,       w_bar_nxt;
  logic [31:0] r_bar_cnt,   w_bar_cnt_nxt;
  mode_t       r_mode,      w_mode_nxt;
  logic [7:0]  r_fnum,      w_fnum_nxt;
  logic [15:0] r_frame_cnt, w_frame_cnt_nxt;
  logic        w_done_nxt;
  logic        w_start;

  logic        r_vsyn, r_href, r_done;
  logic [7:0]  r_data;
  logic        w_vsyn_nxt, w_href_nxt;
  logic [7:0]  w_data_nxt;
  logic [15:0] w_pixel;

  // Colour is evaluated for the upcoming cycle so the data byte is registered
  // in step with HREF.
  cam_pattern_pixel #(
    .SQ_LOG2 (SQ_LOG2)
  ) u_pixel (
    .i_mode  (w_mode_nxt),
    .i_x     (w_x_nxt),
    .i_y     (w_line_nxt),
    .i_bar   (w_bar_nxt),
    .i_frame (w_fnum_nxt),
    .o_pixel (w_pixel)
  );

  // Next-state, position counters and frame bookkeeping.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_line_nxt      = r_line;
    w_x_nxt         = r_x;
    w_phase_nxt     = r_phase;
    w_bar_nxt       = r_bar;
    w_bar_cnt_nxt   = r_bar_cnt;
    w_mode_nxt      = r_mode;
    w_fnum_nxt      = r_fnum;
    w_frame_cnt_nxt = r_frame_cnt;
    w_done_nxt      = 1'b0;
    w_start         = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (bus.enable) w_start = 1'b1;
      end
      ST_VSYNC: begin
        if (r_cnt == LAST_VF) begin
          w_state_nxt = ST_VBACK;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 32'd1;
        end
      end
      ST_VBACK: begin
        if (r_cnt == LAST_VB) begin
          w_state_nxt = ST_HBLANK;
          w_cnt_nxt   = '0;
          w_line_nxt  = '0;
        end else begin
          w_cnt_nxt = r_cnt + 32'd1;
        end
      end
      ST_HBLANK: begin
        if (r_cnt == LAST_HB) begin
          // Every line starts at pixel 0, high byte, first bar.
          w_state_nxt   = ST_ACTIVE;
          w_cnt_nxt     = '0;
          w_x_nxt       = '0;
          w_phase_nxt   = 1'b0;
          w_bar_nxt     = '0;
          w_bar_cnt_nxt = '0;
        end else begin
          w_cnt_nxt = r_cnt + 32'd1;
        end
      end
      ST_ACTIVE: begin
        if (r_cnt == LAST_BYTE) begin
          if (r_line == LAST_LINE) begin
            w_done_nxt      = 1'b1;
            w_frame_cnt_nxt = r_frame_cnt + 16'd1;
            if (bus.enable) w_start = 1'b1;
            else            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_HBLANK;
            w_cnt_nxt   = '0;
            w_line_nxt  = r_line + 16'd1;
          end
        end else begin
          w_cnt_nxt   = r_cnt + 32'd1;
          w_phase_nxt = ~r_phase;
          // Pixel position and bar index step only after the low byte.
          if (r_phase) begin
            w_x_nxt = r_x + 16'd1;
            if (r_bar_cnt == LAST_BPIX) begin
              w_bar_cnt_nxt = '0;
              w_bar_nxt     = r_bar + 3'd1;
            end else begin
              w_bar_cnt_nxt = r_bar_cnt + 32'd1;
            end
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    // Frame start: pattern mode and fill number are frozen for the whole frame.
    // The fill number includes a completion counted on this same edge.
    if (w_start) begin
      w_state_nxt = ST_VSYNC;
      w_cnt_nxt   = '0;
      w_mode_nxt  = mode_t'(bus.mode);
      w_fnum_nxt  = w_frame_cnt_nxt[7:0];
    end
  end

  // Output values for the upcoming cycle; data is forced to zero off-line.
  always_comb begin
    w_vsyn_nxt = (w_state_nxt == ST_VSYNC);
    w_href_nxt = (w_state_nxt == ST_ACTIVE);
    w_data_nxt = 8'h00;
    if (w_href_nxt) w_data_nxt = w_phase_nxt ? w_pixel[7:0] : w_pixel[15:8];
  end

  // State, counters and registered outputs.
  always_ff @(posedge cmos_pclk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_line      <= '0;
      r_x         <= '0;
      r_phase     <= 1'b0;
      r_bar       <= '0;
      r_bar_cnt   <= '0;
      r_mode      <= MODE_BARS;
      r_fnum      <= '0;
      r_frame_cnt <= '0;
      r_vsyn      <= 1'b0;
      r_href      <= 1'b0;
      r_data      <= 8'h00;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_line      <= w_line_nxt;
      r_x         <= w_x_nxt;
      r_phase     <= w_phase_nxt;
      r_bar       <= w_bar_nxt;
      r_bar_cnt   <= w_bar_cnt_nxt;
      r_mode      <= w_mode_nxt;
      r_fnum      <= w_fnum_nxt;
      r_frame_cnt <= w_frame_cnt_nxt;
      r_vsyn      <= w_vsyn_nxt;
      r_href      <= w_href_nxt;
      r_data      <= w_data_nxt;
      r_done      <= w_done_nxt;
    end
  end

  assign bus.cmos_vsyn  = r_vsyn;
  assign bus.cmos_href  = r_href;
  assign bus.cmos_data  = r_data;
  assign bus.frame_done = r_done;
  assign bus.frame_cnt  = r_frame_cnt;

endmodule

// File: tb/tb_cam_pattern_gen.sv
// Bench for cam_pattern_gen with small timing parameters. A frame-time model
// predicts every output on every cycle; directed checks pin literal values.
module tb_cam_pattern_gen;

  localparam int VF    = 8;
  localparam int VB    = 6;
  localparam int HA    = 16;
  localparam int VA    = 4;
  localparam int HB    = 4;
  localparam int BW    = 2;
  localparam int SQ    = 1;
  localparam int LINE  = HB + 2 * HA;
  localparam int FRAME = VF + VB + VA * LINE;

  logic clk = 1'b0;
  logic rst = 1'b1;

  cam_pattern_gen_if bus_if ();

  cam_pattern_gen #(
    .H_ACTIVE (HA),
    .V_ACTIVE (VA),
    .H_BLANK  (HB),
    .V_FRONT  (VF),
    .V_BACK   (VB),
    .BAR_W    (BW),
    .SQ_LOG2  (SQ)
  ) dut (
    .cmos_pclk (clk),
    .rst       (rst),
    .bus       (bus_if)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int start_cyc = 0;

  logic [15:0] bar_tab [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                               16'hF81F, 16'hF800, 16'h001F, 16'h0000};

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (time %0t)", nm, act, exp, $time);
    end
  endtask

  // Wait until the DUT is showing output cycle r of the current run.
  task automatic at_cycle(input int r);
    while (cyc - start_cyc - 1 < r) @(negedge clk);
  endtask

  function automatic logic [15:0] model_pix(input logic [1:0] md, input int x, input int y,
                                            input logic [7:0] fill);
    logic [15:0] xv;
    xv = 16'(x);
    case (md)
      2'd0:    return bar_tab[(x / BW) % 8];
      2'd1:    return {xv[7:3], xv[7:2], xv[7:3]};
      2'd2:    return ((((x >> SQ) ^ (y >> SQ)) & 1) != 0) ? 16'hFFFF : 16'h0000;
      default: return {fill, fill};
    endcase
  endfunction

  // {vsyn, href, data} for cycle t of a frame.
  function automatic logic [9:0] model_out(input bit run, input int t, input logic [1:0] md,
                                           input logic [7:0] fill);
    int k, y, o, b;
    logic [15:0] p;
    if (!run) return 10'd0;
    if (t < VF) return {1'b1, 1'b0, 8'h00};
    if (t < VF + VB) return 10'd0;
    k = t - VF - VB;
    y = k / LINE;
    o = k % LINE;
    if (o < HB) return 10'd0;
    b = o - HB;
    p = model_pix(md, b / 2, y, fill);
    return {1'b0, 1'b1, (b % 2 == 1) ? p[7:0] : p[15:8]};
  endfunction

  // Model state: whether a frame runs, position in it, and its frozen settings.
  bit          m_run  = 1'b0;
  int          m_t    = 0;
  logic [1:0]  m_mode = 2'd0;
  logic [7:0]  m_fill = 8'd0;
  logic [15:0] m_cnt  = 16'd0;
  bit          m_done = 1'b0;
  logic [9:0]  exp_o;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (rst) begin
      m_run  <= 1'b0;
      m_t    <= 0;
      m_cnt  <= 16'd0;
      m_done <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_run && m_t != FRAME - 1) begin
        m_t <= m_t + 1;
      end else begin
        if (m_run) begin
          m_done <= 1'b1;
          m_cnt  <= m_cnt + 16'd1;
        end
        if (bus_if.enable) begin
          m_run  <= 1'b1;
          m_t    <= 0;
          m_mode <= bus_if.mode;
          m_fill <= m_run ? m_cnt[7:0] + 8'd1 : m_cnt[7:0];
        end else begin
          m_run <= 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_o = model_out(m_run, m_t, m_mode, m_fill);
    check("m_vsyn", {15'd0, bus_if.cmos_vsyn}, {15'd0, exp_o[9]});
    check("m_href", {15'd0, bus_if.cmos_href}, {15'd0, exp_o[8]});
    check("m_data", {8'd0, bus_if.cmos_data}, {8'd0, exp_o[7:0]});
    check("m_done", {15'd0, bus_if.frame_done}, {15'd0, m_done});
    check("m_fcnt", bus_if.frame_cnt, m_cnt);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got time %0t, expected finish earlier", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bus_if.enable = 1'b0;
    bus_if.mode   = 2'd0;
    repeat (3) @(negedge clk);
    check("rst_vsyn", {15'd0, bus_if.cmos_vsyn}, 16'd0);
    check("rst_href", {15'd0, bus_if.cmos_href}, 16'd0);
    check("rst_data", {8'd0, bus_if.cmos_data}, 16'd0);
    check("rst_done", {15'd0, bus_if.frame_done}, 16'd0);
    check("rst_fcnt", bus_if.frame_cnt, 16'd0);

    // Colour bars, mode switched mid-frame, then enable dropped in frame 2.
    rst = 1'b0; bus_if.enable = 1'b1; bus_if.mode = 2'd0; start_cyc = cyc;
    at_cycle(0);   check("a_vsyn0", {15'd0, bus_if.cmos_vsyn}, 16'd1);
    at_cycle(7);   check("a_vsyn7", {15'd0, bus_if.cmos_vsyn}, 16'd1);
    at_cycle(8);   check("a_vsyn8", {15'd0, bus_if.cmos_vsyn}, 16'd0);
    at_cycle(17);  check("a_href17", {15'd0, bus_if.cmos_href}, 16'd0);
    at_cycle(18);  check("a_href18", {15'd0, bus_if.cmos_href}, 16'd1);
                   check("a_b0", {8'd0, bus_if.cmos_data}, 16'h00FF);
    at_cycle(22);  check("a_b4", {8'd0, bus_if.cmos_data}, 16'h00FF);
    at_cycle(23);  check("a_b5", {8'd0, bus_if.cmos_data}, 16'h00E0);
    at_cycle(26);  check("a_b8", {8'd0, bus_if.cmos_data}, 16'h0007);
    at_cycle(27);  check("a_b9", {8'd0, bus_if.cmos_data}, 16'h00FF);
    at_cycle(49);  check("a_b31", {8'd0, bus_if.cmos_data}, 16'h0000);
    at_cycle(50);  check("a_href50", {15'd0, bus_if.cmos_href}, 16'd0);
    at_cycle(60);  bus_if.mode = 2'd1;
    at_cycle(70);  check("a_l1_bar4", {8'd0, bus_if.cmos_data}, 16'h00F8);
    at_cycle(157); check("a_href157", {15'd0, bus_if.cmos_href}, 16'd1);
    at_cycle(158); check("a_done158", {15'd0, bus_if.frame_done}, 16'd1);
                   check("a_fcnt158", bus_if.frame_cnt, 16'd1);
                   check("a_vsyn158", {15'd0, bus_if.cmos_vsyn}, 16'd1);
    at_cycle(159); check("a_done159", {15'd0, bus_if.frame_done}, 16'd0);
    at_cycle(176); check("a_grad0", {8'd0, bus_if.cmos_data}, 16'h0000);
    at_cycle(192); check("a_grad8h", {8'd0, bus_if.cmos_data}, 16'h0008);
    at_cycle(193); check("a_grad8l", {8'd0, bus_if.cmos_data}, 16'h0041);
    at_cycle(200); bus_if.enable = 1'b0;
    at_cycle(316); check("a_done316", {15'd0, bus_if.frame_done}, 16'd1);
                   check("a_fcnt316", bus_if.frame_cnt, 16'd2);
                   check("a_idle_vsyn", {15'd0, bus_if.cmos_vsyn}, 16'd0);
    at_cycle(317); check("a_done317", {15'd0, bus_if.frame_done}, 16'd0);
                   check("a_idle_href", {15'd0, bus_if.cmos_href}, 16'd0);
                   check("a_idle_data", {8'd0, bus_if.cmos_data}, 16'd0);
    at_cycle(330); check("a_idle_vsyn2", {15'd0, bus_if.cmos_vsyn}, 16'd0);
                   check("a_idle_fcnt", bus_if.frame_cnt, 16'd2);

    // Frame-number fill over three frames.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0; bus_if.enable = 1'b1; bus_if.mode = 2'd3; start_cyc = cyc;
    at_cycle(18);  check("b_fill0", {8'd0, bus_if.cmos_data}, 16'h0000);
                   check("b_href18", {15'd0, bus_if.cmos_href}, 16'd1);
    at_cycle(158); check("b_done158", {15'd0, bus_if.frame_done}, 16'd1);
                   check("b_fcnt1", bus_if.frame_cnt, 16'd1);
    at_cycle(176); check("b_fill1", {8'd0, bus_if.cmos_data}, 16'h0001);
    at_cycle(316); check("b_done316", {15'd0, bus_if.frame_done}, 16'd1);
                   check("b_fcnt2", bus_if.frame_cnt, 16'd2);
    at_cycle(334); check("b_fill2", {8'd0, bus_if.cmos_data}, 16'h0002);
    at_cycle(340); bus_if.enable = 1'b0;
    at_cycle(474); check("b_done474", {15'd0, bus_if.frame_done}, 16'd1);
                   check("b_fcnt3", bus_if.frame_cnt, 16'd3);
    at_cycle(475); check("b_fcnt3b", bus_if.frame_cnt, 16'd3);
                   check("b_idle_vsyn", {15'd0, bus_if.cmos_vsyn}, 16'd0);

    // Checkerboard, then reset in the middle of a line.
    bus_if.enable = 1'b1; bus_if.mode = 2'd2; start_cyc = cyc;
    at_cycle(18);  check("c_l0x0", {8'd0, bus_if.cmos_data}, 16'h0000);
    at_cycle(22);  check("c_l0x2", {8'd0, bus_if.cmos_data}, 16'h00FF);
    at_cycle(26);  check("c_l0x4", {8'd0, bus_if.cmos_data}, 16'h0000);
    at_cycle(90);  check("c_l2x0", {8'd0, bus_if.cmos_data}, 16'h00FF);
    at_cycle(94);  check("c_l2x2", {8'd0, bus_if.cmos_data}, 16'h0000);
    at_cycle(100); check("c_href100", {15'd0, bus_if.cmos_href}, 16'd1);
                   rst = 1'b1;
    at_cycle(101); check("c_rst_vsyn", {15'd0, bus_if.cmos_vsyn}, 16'd0);
                   check("c_rst_href", {15'd0, bus_if.cmos_href}, 16'd0);
                   check("c_rst_data", {8'd0, bus_if.cmos_data}, 16'd0);
                   check("c_rst_done", {15'd0, bus_if.frame_done}, 16'd0);
                   check("c_rst_fcnt", bus_if.frame_cnt, 16'd0);
    rst = 1'b0; start_cyc = cyc;
    at_cycle(0);   check("c_restart_vsyn", {15'd0, bus_if.cmos_vsyn}, 16'd1);
    at_cycle(40);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
